// File: rtl/demux_1x2_stream.sv
// demux_1x2_stream: registered 1-to-2 valid/ready stream demultiplexer.
// Each output channel owns a 2-entry FIFO so one stalled consumer never
// blocks words headed to the other channel. Channel index 1 = a, 0 = b,
// which lines up directly with in_sel.

module demux_1x2_stream_fifo #(
  parameter int DATAWIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 i_push,
  input  logic [DATAWIDTH-1:0] i_data,
  input  logic                 i_ready,
  output logic [DATAWIDTH-1:0] o_data,
  output logic                 o_valid,
  output logic [1:0]           o_level,
  output logic                 o_full
);

  logic [1:0][DATAWIDTH-1:0] r_mem;
  logic                      r_wr_ptr;
  logic                      r_rd_ptr;
  logic [1:0]                r_count;
  logic                      w_push;
  logic                      w_pop;
  logic [1:0]                w_count_nxt;

  // A push into a full FIFO is dropped here as well, even though the
  // top already withholds in_ready; keeps the count inside 0..2.
  assign o_full  = (r_count == 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = o_valid & i_ready;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_count;

  // Occupancy update: simultaneous push and pop leaves the count alone.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage, pointers and count; reset clears storage so the head reads 0.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_mem    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
      r_wr_ptr <= r_wr_ptr ^ w_push;
      r_rd_ptr <= r_rd_ptr ^ w_pop;
      r_count  <= w_count_nxt;
    end
  end

endmodule

module demux_1x2_stream #(
  parameter int DATAWIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] a_data,
  output logic                 a_valid,
  input  logic                 a_ready,
  output logic [1:0]           a_level,
  output logic [DATAWIDTH-1:0] b_data,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [1:0]           b_level
);

  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0][DATAWIDTH-1:0] w_data;
  logic [NUM_CH-1:0][1:0]           w_level;
  logic [NUM_CH-1:0]                w_valid;
  logic [NUM_CH-1:0]                w_full;
  logic [NUM_CH-1:0]                w_ready;
  logic [NUM_CH-1:0]                w_push;
  logic                             w_accept;

  // in_ready only looks at the target's registered count, never at the
  // consumer readys, so a full channel is refused even while it drains.
  assign in_ready = ~Rst & ~w_full[in_sel];
  assign w_accept = in_valid & in_ready;
  assign w_ready  = {a_ready, b_ready};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_push[gi] = w_accept & (in_sel == gi[0]);

      demux_1x2_stream_fifo #(.DATAWIDTH(DATAWIDTH)) u_fifo (
        .Clk     (Clk),
        .Rst     (Rst),
        .i_push  (w_push[gi]),
        .i_data  (in_data),
        .i_ready (w_ready[gi]),
        .o_data  (w_data[gi]),
        .o_valid (w_valid[gi]),
        .o_level (w_level[gi]),
        .o_full  (w_full[gi])
      );
    end
  endgenerate

  assign a_data  = w_data[1];
  assign a_valid = w_valid[1];
  assign a_level = w_level[1];
  assign b_data  = w_data[0];
  assign b_valid = w_valid[0];
  assign b_level = w_level[0];

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Directed bench for demux_1x2_stream: reset, steering, full/refuse,
// streaming, random-backpressure scoreboard and head-hold stability.

module tb_demux_1x2_stream;

  localparam int DW = 16;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a_data, b_data;
  logic          a_valid, b_valid;
  logic          a_ready = 1'b0, b_ready = 1'b0;
  logic [1:0]    a_level, b_level;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  demux_1x2_stream #(.DATAWIDTH(DW)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready), .a_level(a_level),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready), .b_level(b_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  logic [DW-1:0] q[$];
  int            sent, recv;
  logic          pop, acc;

  initial begin
    // ---- reset with a word offered ----
    in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h0055;
    #2;
    chk("rst_in_ready", in_ready, 0);
    tick; tick;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_level", a_level, 0);
    chk("rst_b_level", b_level, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_b_data", b_data, 0);
    in_valid = 1'b0;
    Rst = 1'b0;
    #1;
    chk("rel_rdy_sel1", in_ready, 1);
    in_sel = 1'b0; #1;
    chk("rel_rdy_sel0", in_ready, 1);

    // ---- reset mid-stream ----
    tick;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h0077; tick;
    in_sel = 1'b0; in_data = 16'h0088; tick;
    chk("mid_a_level", a_level, 1);
    chk("mid_b_level", b_level, 1);
    #3 Rst = 1'b1; #1;
    chk("mid_rst_a_valid", a_valid, 0);
    chk("mid_rst_b_valid", b_valid, 0);
    chk("mid_rst_a_level", a_level, 0);
    chk("mid_rst_b_level", b_level, 0);
    chk("mid_rst_a_data", a_data, 0);
    chk("mid_rst_b_data", b_data, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    tick;
    Rst = 1'b0; #1;
    chk("mid_rel_rdy", in_ready, 1);
    chk("mid_rel_a_level", a_level, 0);

    // ---- steering ----
    tick;
    a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h1111;
    chk("st_a_empty", a_valid, 0);
    tick;
    chk("st_a1_valid", a_valid, 1);
    chk("st_a1_data", a_data, 16'h1111);
    chk("st_b_empty", b_valid, 0);
    in_sel = 1'b0; in_data = 16'h2222;
    tick;
    chk("st_b_valid", b_valid, 1);
    chk("st_b_data", b_data, 16'h2222);
    chk("st_a_drained", a_valid, 0);
    in_sel = 1'b1; in_data = 16'h3333;
    tick;
    chk("st_a2_data", a_data, 16'h3333);
    chk("st_a2_valid", a_valid, 1);
    chk("st_b_drained", b_valid, 0);
    in_valid = 1'b0;
    tick;
    chk("st_a_final", a_valid, 0);

    // ---- fill / full ----
    a_ready = 1'b0; b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 16'hA001; tick;
    in_data = 16'hA002; tick;
    chk("full_a_level", a_level, 2);
    chk("full_rdy_sel1", in_ready, 0);
    in_sel = 1'b0; in_data = 16'hB001; #1;
    chk("full_rdy_sel0", in_ready, 1);
    tick;
    chk("full_b_level", b_level, 1);
    chk("full_b_data", b_data, 16'hB001);
    chk("full_a_stays", a_level, 2);
    chk("full_a_head", a_data, 16'hA001);

    // ---- full with simultaneous pop ----
    in_sel = 1'b1; in_data = 16'hA003; a_ready = 1'b1; #1;
    chk("fp_rdy_refused", in_ready, 0);
    tick;
    chk("fp_a_level1", a_level, 1);
    chk("fp_a_head2", a_data, 16'hA002);
    chk("fp_rdy_next", in_ready, 1);
    tick;
    chk("fp_a_level2", a_level, 1);
    chk("fp_a_head3", a_data, 16'hA003);
    in_valid = 1'b0;
    tick;
    chk("fp_a_empty", a_valid, 0);
    b_ready = 1'b1;
    tick;
    chk("fp_b_empty", b_valid, 0);

    // ---- streaming 64 words to b ----
    in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 64; i++) begin
      in_data = DW'(16'h4000 + i);
      #1;
      chk("str_rdy", in_ready, 1);
      tick;
      chk("str_b_valid", b_valid, 1);
      chk("str_b_data", b_data, DW'(16'h4000 + i));
      chk("str_b_level", b_level, 1);
    end
    in_valid = 1'b0;
    tick;
    chk("str_b_empty", b_valid, 0);

    // ---- random backpressure on b against a scoreboard ----
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 3000 && (sent < 100 || q.size() != 0); cyc++) begin
      in_sel   = 1'b0;
      in_valid = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data  = DW'(16'h6000 + sent);
      b_ready  = 1'($urandom_range(0, 1));
      #1;
      pop = b_valid & b_ready;
      acc = in_valid & in_ready;
      if (pop) begin
        if (q.size() == 0) chk("sb_spurious", 1, 0);
        else begin
          chk("sb_data", b_data, q.pop_front());
          recv++;
        end
      end
      if (acc) begin
        q.push_back(in_data);
        sent++;
      end
      tick;
    end
    chk("sb_sent", sent, 100);
    chk("sb_recv", recv, 100);
    chk("sb_left", q.size(), 0);
    in_valid = 1'b0; b_ready = 1'b0;
    tick;
    chk("sb_b_empty", b_valid, 0);

    // ---- head hold while stalled ----
    a_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 16'hC0DE;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1; in_data = 16'hC0DF;
      end else begin
        in_valid = 1'b0;
      end
      chk("hold_valid", a_valid, 1);
      chk("hold_data", a_data, 16'hC0DE);
      tick;
    end
    in_valid = 1'b0;
    chk("hold_level", a_level, 2);
    a_ready = 1'b1;
    tick;
    chk("hold_next", a_data, 16'hC0DF);
    tick;
    chk("hold_empty", a_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
